ex_stage: RTL and testbench

- Execute pipeline stage of the 5-stage MIPS32 core.
- Latches decoded operands from ID and drives the existing one-hot ALU.
- Owns the HI/LO registers, a single-cycle multiply and an iterative divider.
- Presents the EX result to MEM under a valid/allowin handshake, stalling while a divide is in progress.

---
 rtl/ex_stage_pkg.sv | 52 +++++
 rtl/ex_stage_alu.sv | 46 ++++
 rtl/ex_stage_div.sv | 81 ++++++++
 rtl/ex_stage.sv | 123 ++++++++++++
 tb/tb_ex_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the EX stage.
//   - ALU one-hot op bit indices (same layout as the core's alu.vh)
//   - MD_* / HILO_* one-hot op bit indices
//   - ID->EX stage register layout and field widths
package ex_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int ALU_OP_W  = 12;
  localparam int MD_OP_W   = 4;
  localparam int HILO_OP_W = 4;

  // Divider latency from EX entry: 1 setup cycle + 32 iterations.
  localparam int DIV_CYCLES = 33;

  // ALU op bit indices
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Multiply/divide op bit indices: {divu,div,multu,mult}
  localparam int MD_MULT  = 0;
  localparam int MD_MULTU = 1;
  localparam int MD_DIV   = 2;
  localparam int MD_DIVU  = 3;

  // HI/LO move op bit indices: {mtlo,mthi,mflo,mfhi}
  localparam int HILO_MFHI = 0;
  localparam int HILO_MFLO = 1;
  localparam int HILO_MTHI = 2;
  localparam int HILO_MTLO = 3;

  typedef struct packed {
    logic [ALU_OP_W-1:0]  alu_op;
    logic [MD_OP_W-1:0]   md_op;
    logic [HILO_OP_W-1:0] hilo_op;
    logic [DATA_W-1:0]    src1;
    logic [DATA_W-1:0]    src2;
    logic [REG_W-1:0]     dest;
    logic [DATA_W-1:0]    pc;
  } id_ex_t;

endpackage

// File: rtl/ex_stage_alu.sv
// alu: combinational one-hot ALU.
//   alu_op     in  12  one-hot op (ALU_* indices)
//   alu_src1   in  32  operand a (shift amount for shifts)
//   alu_src2   in  32  operand b (shifted value / lui immediate)
//   alu_result out 32  OR of the selected op result; 0 when no op bit set
module alu
  import ex_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   alu_src1,
  input  logic [DATA_W-1:0]   alu_src2,
  output logic [DATA_W-1:0]   alu_result
);

  logic          use_sub;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W:0]   add_sum;
  logic          slt_r, sltu_r;
  logic [4:0]    sa;

  // add/sub/slt/sltu share one adder: a + ~b + 1 for the subtracting ops
  assign use_sub = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
  assign add_b   = use_sub ? ~alu_src2 : alu_src2;
  assign add_sum = {1'b0, alu_src1} + {1'b0, add_b} + {{DATA_W{1'b0}}, use_sub};

  assign slt_r  = (alu_src1[31] & ~alu_src2[31]) |
                  (~(alu_src1[31] ^ alu_src2[31]) & add_sum[31]);
  assign sltu_r = ~add_sum[DATA_W];
  assign sa     = alu_src1[4:0];

  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_ADD] | alu_op[ALU_SUB]) alu_result |= add_sum[DATA_W-1:0];
    if (alu_op[ALU_SLT])  alu_result |= {31'b0, slt_r};
    if (alu_op[ALU_SLTU]) alu_result |= {31'b0, sltu_r};
    if (alu_op[ALU_AND])  alu_result |= alu_src1 & alu_src2;
    if (alu_op[ALU_NOR])  alu_result |= ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OR])   alu_result |= alu_src1 | alu_src2;
    if (alu_op[ALU_XOR])  alu_result |= alu_src1 ^ alu_src2;
    if (alu_op[ALU_SLL])  alu_result |= alu_src2 << sa;
    if (alu_op[ALU_SRL])  alu_result |= alu_src2 >> sa;
    if (alu_op[ALU_SRA])  alu_result |= $unsigned($signed(alu_src2) >>> sa);
    if (alu_op[ALU_LUI])  alu_result |= {alu_src2[15:0], 16'b0};
  end

endmodule

// File: rtl/ex_stage_div.sv
// div_iter: iterative restoring radix-2 divider on operand magnitudes.
//   clk, resetn  clock / async active-low reset
//   start        load operands (ignored while running or holding a result)
//   abort        return to idle, drops any held result (flush or consume)
//   div_signed   treat a/b as two's complement
//   a, b         dividend / divisor, held stable by the caller while busy
//   done         result valid; held until abort
//   quotient     signed/unsigned quotient (0xFFFFFFFF on divide by zero)
//   remainder    remainder, sign follows the dividend
module div_iter
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic              active_q, done_q, negq_q, negr_q, dz_q;
  logic [4:0]        cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [DATA_W-1:0] a_mag, b_mag, rem_nx;
  logic [DATA_W+1:0] diff;
  logic              ge;

  assign a_mag = (div_signed & a[31]) ? -a : a;
  assign b_mag = (div_signed & b[31]) ? -b : b;

  // Shift in the next dividend bit and try subtracting the divisor.
  assign diff   = {1'b0, rem_q, quo_q[31]} - {2'b0, dvs_q};
  assign ge     = ~diff[DATA_W+1];
  assign rem_nx = ge ? diff[DATA_W-1:0] : {rem_q[DATA_W-2:0], quo_q[31]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (abort) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (start && !active_q && !done_q) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= a_mag;
      dvs_q    <= b_mag;
      negq_q   <= div_signed & (a[31] ^ b[31]);
      negr_q   <= div_signed & a[31];
      dz_q     <= (b == '0);
    end else if (active_q) begin
      rem_q <= rem_nx;
      quo_q <= {quo_q[DATA_W-2:0], ge};
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'(DIV_CYCLES - 2)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end
    end
  end

  // Divide by zero: the magnitude loop already yields remainder = |a|, which
  // re-signed gives a; only the quotient needs forcing to all ones.
  // 0x80000000 / -1 falls out naturally (magnitude 0x80000000, positive sign).
  assign done      = done_q;
  assign quotient  = dz_q ? '1 : (negq_q ? -quo_q : quo_q);
  assign remainder = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage.
//   clk, resetn       clock / async active-low reset
//   flush             kill the resident instruction, abort divide, no HI/LO write
//   id_valid/ex_allowin   ID->EX handshake
//   id_alu_op, id_md_op, id_hilo_op, id_src1, id_src2, id_dest, id_pc  ID fields
//   mem_allowin/ex_valid  EX->MEM handshake
//   ex_result, ex_dest, ex_pc   result to MEM
//   ex_busy           divider running (for the ID hazard unit)
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 ex_allowin,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic [MD_OP_W-1:0]   id_md_op,
  input  logic [HILO_OP_W-1:0] id_hilo_op,
  input  logic [DATA_W-1:0]    id_src1,
  input  logic [DATA_W-1:0]    id_src2,
  input  logic [REG_W-1:0]     id_dest,
  input  logic [DATA_W-1:0]    id_pc,
  input  logic                 mem_allowin,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    ex_result,
  output logic [REG_W-1:0]     ex_dest,
  output logic [DATA_W-1:0]    ex_pc,
  output logic                 ex_busy
);

  logic              valid_q;
  id_ex_t            st_q, st_d;
  logic [DATA_W-1:0] hi_q, lo_q, hi_d, lo_d;
  logic [DATA_W-1:0] alu_out, div_quo, div_rem;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic              is_div, div_done, ready_go, out_fire;

  assign st_d = '{alu_op: id_alu_op, md_op: id_md_op, hilo_op: id_hilo_op,
                  src1: id_src1, src2: id_src2, dest: id_dest, pc: id_pc};

  assign is_div     = st_q.md_op[MD_DIV] | st_q.md_op[MD_DIVU];
  assign ready_go   = !(is_div && !div_done);
  assign ex_allowin = !valid_q || (ready_go && mem_allowin);
  assign ex_valid   = valid_q && ready_go;
  assign out_fire   = ex_valid && mem_allowin;
  assign ex_busy    = valid_q && is_div && !div_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      st_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (ex_allowin) begin
      valid_q <= id_valid;
      if (id_valid) st_q <= st_d;
    end
  end

  alu u_alu (
    .alu_op     (st_q.alu_op),
    .alu_src1   (st_q.src1),
    .alu_src2   (st_q.src2),
    .alu_result (alu_out)
  );

  // Consuming the result (or a flush) returns the divider to idle, so a
  // following divide entering on the same edge starts cleanly next cycle.
  div_iter u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start      (valid_q && is_div && !flush),
    .abort      (flush || out_fire),
    .div_signed (st_q.md_op[MD_DIV]),
    .a          (st_q.src1),
    .b          (st_q.src2),
    .done       (div_done),
    .quotient   (div_quo),
    .remainder  (div_rem)
  );

  // Low 64 bits of the sign-/zero-extended products are the exact results.
  assign prod_s = {{DATA_W{st_q.src1[31]}}, st_q.src1} * {{DATA_W{st_q.src2[31]}}, st_q.src2};
  assign prod_u = {{DATA_W{1'b0}}, st_q.src1} * {{DATA_W{1'b0}}, st_q.src2};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (out_fire && !flush) begin
      if (st_q.md_op[MD_MULT])       {hi_d, lo_d} = prod_s;
      else if (st_q.md_op[MD_MULTU]) {hi_d, lo_d} = prod_u;
      else if (is_div) begin
        lo_d = div_quo;
        hi_d = div_rem;
      end
      if (st_q.hilo_op[HILO_MTHI]) hi_d = st_q.src1;
      if (st_q.hilo_op[HILO_MTLO]) lo_d = st_q.src1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    ex_result = alu_out;
    if (st_q.hilo_op[HILO_MFHI])      ex_result = hi_q;
    else if (st_q.hilo_op[HILO_MFLO]) ex_result = lo_q;
    else if (|st_q.md_op || st_q.hilo_op[HILO_MTHI] || st_q.hilo_op[HILO_MTLO])
      ex_result = '0;
  end

  assign ex_dest = st_q.dest;
  assign ex_pc   = st_q.pc;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with a result scoreboard.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, flush, id_valid, mem_allowin;
  logic [11:0] id_alu_op;
  logic [3:0]  id_md_op, id_hilo_op;
  logic [31:0] id_src1, id_src2, id_pc;
  logic [4:0]  id_dest;
  logic        ex_allowin, ex_valid, ex_busy;
  logic [31:0] ex_result, ex_pc;
  logic [4:0]  ex_dest;

  ex_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid),
    .ex_allowin(ex_allowin), .id_alu_op(id_alu_op), .id_md_op(id_md_op),
    .id_hilo_op(id_hilo_op), .id_src1(id_src1), .id_src2(id_src2),
    .id_dest(id_dest), .id_pc(id_pc), .mem_allowin(mem_allowin),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_dest(ex_dest),
    .ex_pc(ex_pc), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pc_n = 32'hBFC0_0000;

  localparam logic [11:0] A_NONE = 12'b0;
  localparam logic [11:0] A_ADD  = 12'b1 << ALU_ADD;
  localparam logic [11:0] A_SUB  = 12'b1 << ALU_SUB;
  localparam logic [11:0] A_OR   = 12'b1 << ALU_OR;
  localparam logic [11:0] A_XOR  = 12'b1 << ALU_XOR;
  localparam logic [3:0]  M_NONE  = 4'b0;
  localparam logic [3:0]  M_MULT  = 4'b1 << MD_MULT;
  localparam logic [3:0]  M_MULTU = 4'b1 << MD_MULTU;
  localparam logic [3:0]  M_DIV   = 4'b1 << MD_DIV;
  localparam logic [3:0]  M_DIVU  = 4'b1 << MD_DIVU;
  localparam logic [3:0]  H_NONE = 4'b0;
  localparam logic [3:0]  H_MFHI = 4'b1 << HILO_MFHI;
  localparam logic [3:0]  H_MFLO = 4'b1 << HILO_MFLO;
  localparam logic [3:0]  H_MTHI = 4'b1 << HILO_MTHI;
  localparam logic [3:0]  H_MTLO = 4'b1 << HILO_MTLO;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: at the falling edge retire to the scoreboard, then advance.
  task automatic tick(output logic acc);
    exp_t e;
    @(negedge clk);
    acc = ex_allowin && id_valid && !flush;
    if (ex_valid && mem_allowin && !flush) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("result", ex_result, e.res);
        chk("dest", 32'(ex_dest), 32'(e.dest));
        chk("pc", ex_pc, e.pc);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic issue(input logic [11:0] alu, input logic [3:0] md, input logic [3:0] hl,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic [31:0] exp);
    logic acc;
    exp_t e;
    id_alu_op = alu; id_md_op = md; id_hilo_op = hl;
    id_src1 = a; id_src2 = b; id_dest = dest; id_pc = pc_n; id_valid = 1'b1;
    e.res = exp; e.dest = dest; e.pc = pc_n;
    sb.push_back(e);
    pc_n += 4;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) tick(acc);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    id_valid = 1'b0;
  endtask

  initial begin
    int   busy_n, first_v;
    exp_t dropped;
    resetn = 1'b0; flush = 1'b0; id_valid = 1'b0; mem_allowin = 1'b1;
    id_alu_op = '0; id_md_op = '0; id_hilo_op = '0;
    id_src1 = '0; id_src2 = '0; id_dest = '0; id_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_result", ex_result, 32'd0);
    chk("rst_dest", 32'(ex_dest), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_busy", 32'(ex_busy), 32'd0);
    chk("rst_allowin", 32'(ex_allowin), 32'd1);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // back-to-back ALU ops
    issue(A_ADD, M_NONE, H_NONE, 32'd5, 32'd7, 5'd1, 32'h0000000C);
    chk("b2b_allowin", 32'(ex_allowin), 32'd1);
    issue(A_SUB, M_NONE, H_NONE, 32'd3, 32'd5, 5'd2, 32'hFFFFFFFE);
    idle(2);

    // MEM backpressure
    mem_allowin = 1'b0;
    issue(A_OR, M_NONE, H_NONE, 32'hF0, 32'h0F, 5'd3, 32'h000000FF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_result", ex_result, 32'h000000FF);
      chk("bp_allowin", 32'(ex_allowin), 32'd0);
      @(posedge clk); #1;
    end
    mem_allowin = 1'b1;
    issue(A_XOR, M_NONE, H_NONE, 32'hFF, 32'h0F, 5'd4, 32'h000000F0);

    // multiply then HI/LO reads
    issue(A_NONE, M_MULT, H_NONE, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd0);
    issue(A_NONE, M_NONE, H_MFHI, 32'd0, 32'd0, 5'd5, 32'hFFFFFFFF);
    issue(A_NONE, M_NONE, H_MFLO, 32'd0, 32'd0, 5'd6, 32'hFFFFFFFE);
    issue(A_NONE, M_MULTU, H_NONE, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd0);
    issue(A_NONE, M_NONE, H_MFHI, 32'd0, 32'd0, 5'd7, 32'h00000001);
    idle(2);

    // signed divide -7/2: count busy cycles and entry-to-valid latency
    issue(A_NONE, M_DIV, H_NONE, 32'hFFFFFFF9, 32'd2, 5'd0, 32'd0);
    mem_allowin = 1'b0;
    busy_n = 0; first_v = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ex_valid) begin first_v = c; break; end
      if (ex_busy) busy_n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("div_busy_cycles", 32'(busy_n), 32'd33);
    chk("div_valid_cycle", 32'(first_v), 32'd33);
    chk("div_busy_done", 32'(ex_busy), 32'd0);
    mem_allowin = 1'b1;
    issue(A_NONE, M_NONE, H_MFLO, 32'd0, 32'd0, 5'd8, 32'hFFFFFFFD);
    issue(A_NONE, M_NONE, H_MFHI, 32'd0, 32'd0, 5'd9, 32'hFFFFFFFF);

    // edge divides
    issue(A_NONE, M_DIVU, H_NONE, 32'd5, 32'd0, 5'd0, 32'd0);
    issue(A_NONE, M_NONE, H_MFLO, 32'd0, 32'd0, 5'd10, 32'hFFFFFFFF);
    issue(A_NONE, M_NONE, H_MFHI, 32'd0, 32'd0, 5'd11, 32'h00000005);
    issue(A_NONE, M_DIV, H_NONE, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'd0);
    issue(A_NONE, M_NONE, H_MFLO, 32'd0, 32'd0, 5'd12, 32'h80000000);
    issue(A_NONE, M_NONE, H_MFHI, 32'd0, 32'd0, 5'd13, 32'h00000000);
    idle(2);

    // flush coinciding with transfer-out of mthi: HI must not change
    issue(A_NONE, M_NONE, H_MTHI, 32'hAA, 32'd0, 5'd0, 32'd0);
    flush = 1'b1;
    dropped = sb.pop_back();
    @(posedge clk); #1;
    flush = 1'b0;
    issue(A_NONE, M_NONE, H_MFHI, 32'd0, 32'd0, 5'd14, 32'h00000000);

    // flush mid-divide
    issue(A_NONE, M_NONE, H_MTLO, 32'h1234, 32'd0, 5'd0, 32'd0);
    issue(A_NONE, M_DIVU, H_NONE, 32'd100, 32'd7, 5'd0, 32'd0);
    idle(9);
    @(negedge clk);
    chk("fl_busy_before", 32'(ex_busy), 32'd1);
    flush = 1'b1;
    id_alu_op = A_ADD; id_md_op = M_NONE; id_hilo_op = H_NONE;
    id_src1 = 32'd1; id_src2 = 32'd1; id_dest = 5'd20; id_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    dropped = sb.pop_back();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_busy", 32'(ex_busy), 32'd0);
    chk("fl_allowin", 32'(ex_allowin), 32'd1);
    issue(A_NONE, M_NONE, H_MFLO, 32'd0, 32'd0, 5'd15, 32'h00001234);
    issue(A_NONE, M_NONE, H_MFHI, 32'd0, 32'd0, 5'd16, 32'h00000000);
    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
